// File: rtl/neuron_accumulator_pkg.sv
// Shared types for the neuron datapath: accumulator FSM states, activation selector
// and the default fan-in.
package AF;

  localparam int unsigned DEFAULT_N_INPUTS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } Acc_State;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_STEP     = 2'd2
  } Act_Func;

endpackage

// File: rtl/neuron_accumulator_mac_step.sv
// One multiply-accumulate step in real arithmetic: acc_out = acc_in + x*w.
module mac_step (
  input  real acc_in,
  input  real x,
  input  real w,
  output real acc_out
);

  assign acc_out = acc_in + x * w;

endmodule

// File: rtl/neuron_accumulator.sv
// Sums N_INPUTS x*w products per vector and holds the result for the activation stage.
// Optional bias on the first beat is enabled by defining NEURON_ACC_BIAS_EN.
module neuron_accumulator
  import AF::*;
#(
  parameter int unsigned N_INPUTS = DEFAULT_N_INPUTS
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  real  x,
  input  real  w,
`ifdef NEURON_ACC_BIAS_EN
  input  real  bias,
`endif
  output logic out_valid,
  input  logic out_ready,
  output real  sum,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  Acc_State         r_state;
  real              r_acc;
  real              r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic             r_busy;

  real  w_acc_base;
  real  w_mac_out;
  logic w_accept;

  // Beats are refused in HOLD and while reset is asserted.
  assign in_ready = !rst && (r_state != HOLD);
  assign w_accept = in_valid && in_ready;

  // The first beat of a vector seeds from the bias (or zero), later beats from the running sum.
`ifdef NEURON_ACC_BIAS_EN
  assign w_acc_base = (r_state == IDLE) ? bias : r_acc;
`else
  assign w_acc_base = (r_state == IDLE) ? 0.0 : r_acc;
`endif

  mac_step u_mac_step (
    .acc_in  (w_acc_base),
    .x       (x),
    .w       (w),
    .acc_out (w_mac_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 0.0;
      r_count     <= '0;
      r_sum       <= 0.0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= w_mac_out;
            r_count <= CNT_W'(1);
            if (N_INPUTS == 1) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_sum       <= w_mac_out;
            end else begin
              r_state <= ACCUM;
              r_busy  <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_mac_out;
            r_count <= r_count + CNT_W'(1);
            if (r_count == LAST_CNT) begin
              r_state     <= HOLD;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_sum       <= w_mac_out;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_acc       <= 0.0;
            r_count     <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: a 4-input instance and a 1-input instance.
module tb_neuron_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  real  x, w, bias, sum, sum1;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef NEURON_ACC_BIAS_EN
  localparam real EXP_VEC  = 5.5;
  localparam real EXP_ONE  = 7.0;
`else
  localparam real EXP_VEC  = 5.0;
  localparam real EXP_ONE  = 6.0;
`endif

  neuron_accumulator #(.N_INPUTS(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
`ifdef NEURON_ACC_BIAS_EN
    .bias      (bias),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  neuron_accumulator #(.N_INPUTS(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .x         (x),
    .w         (w),
`ifdef NEURON_ACC_BIAS_EN
    .bias      (bias),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .busy      (busy1)
  );

  task automatic chk(input string tag, input real got, input real exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %f expected %f", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input real xv, input real wv, input real bv);
    in_valid = 1'b1;
    x        = xv;
    w        = wv;
    bias     = bv;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid1  = 1'b0;
    out_ready  = 1'b1;
    out_ready1 = 1'b1;
    x          = 0.0;
    w          = 0.0;
    bias       = 0.0;
    tick();
    tick();

    chk("rst_in_ready",  real'(in_ready),  0.0);
    chk("rst_out_valid", real'(out_valid), 0.0);
    chk("rst_busy",      real'(busy),      0.0);
    chk("rst_sum",       sum,              0.0);

    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", real'(in_ready), 1.0);

    // Back-to-back vector; bias on later beats must be ignored.
    beat(1.0, 0.5, 0.5);
    chk("t1_busy_b1", real'(busy),      1.0);
    chk("t1_ov_b1",   real'(out_valid), 0.0);
    beat(2.0, 0.5, 9.0);
    beat(3.0, 0.5, 9.0);
    chk("t1_ov_b3",   real'(out_valid), 0.0);
    beat(4.0, 0.5, 9.0);
    chk("t1_ov_b4",   real'(out_valid), 1.0);
    chk("t1_sum",     sum,              EXP_VEC);
    chk("t1_in_rdy",  real'(in_ready),  0.0);
    tick();
    chk("t1_ov_done", real'(out_valid), 0.0);
    chk("t1_rdy_idle", real'(in_ready), 1.0);
    chk("t1_sum_kept", sum,             EXP_VEC);

    // Two bubbles between beats 2 and 3, then backpressure in HOLD.
    out_ready = 1'b0;
    beat(1.0, 0.5, 0.5);
    beat(2.0, 0.5, 0.5);
    tick();
    tick();
    chk("t2_busy_gap", real'(busy),      1.0);
    chk("t2_ov_gap",   real'(out_valid), 0.0);
    beat(3.0, 0.5, 0.5);
    chk("t2_ov_b3",    real'(out_valid), 0.0);
    beat(4.0, 0.5, 0.5);
    chk("t2_ov_b4",    real'(out_valid), 1.0);
    chk("t2_sum",      sum,              EXP_VEC);

    in_valid = 1'b1;
    x        = 100.0;
    w        = 100.0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_sum",  sum,              EXP_VEC);
      chk("t3_hold_rdy",  real'(in_ready),  0.0);
      chk("t3_hold_ov",   real'(out_valid), 1.0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3_rel_ov",   real'(out_valid), 0.0);
    chk("t3_rel_rdy",  real'(in_ready),  1.0);
    chk("t3_rel_busy", real'(busy),      0.0);

    // Abort a partial vector with reset, then run a fresh one.
    beat(5.0, 5.0, 0.0);
    beat(5.0, 5.0, 0.0);
    rst = 1'b1;
    tick();
    chk("t4_rst_ov",   real'(out_valid), 0.0);
    chk("t4_rst_busy", real'(busy),      0.0);
    chk("t4_rst_sum",  sum,              0.0);
    chk("t4_rst_rdy",  real'(in_ready),  0.0);
    rst = 1'b0;
    tick();
    chk("t4_no_pulse", real'(out_valid), 0.0);
    for (int i = 0; i < 4; i++) beat(1.0, -1.0, 0.0);
    chk("t4_ov",       real'(out_valid), 1.0);
    chk("t4_sum",      sum,              -4.0);
    tick();

    // Single-input instance goes straight to HOLD.
    in_valid1 = 1'b1;
    x         = 3.0;
    w         = 2.0;
    bias      = 1.0;
    tick();
    in_valid1 = 1'b0;
    chk("t5_ov",    real'(out_valid1), 1.0);
    chk("t5_sum",   sum1,              EXP_ONE);
    chk("t5_rdy",   real'(in_ready1),  0.0);
    chk("t5_busy",  real'(busy1),      0.0);
    tick();
    chk("t5_ov_done", real'(out_valid1), 0.0);
    chk("t5_sum_kept", sum1,             EXP_ONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
